// File: rtl/round_pkg.sv
// round_pkg: shared tie-mode enum and width helpers for the rounding scheduler
package round_pkg;
  typedef enum logic {RND_EVEN = 1'b0, RND_ODD = 1'b1} rnd_mode_e;
  function automatic int shift_of(int win, int wout);
    return win - wout;
  endfunction
  function automatic int id_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/round_sched_if.sv
// round_sched_if: requester-side and result-side valid/ready bundle
interface round_sched_if
  import round_pkg::*;
#(
  parameter int REQ_NUM = 4,
  parameter int DATA_WIDTH_IN = 40,
  parameter int DATA_WIDTH_OUT = 16
);
  localparam int ID_W = id_w(REQ_NUM);
  logic [REQ_NUM-1:0] s_tvalid_i;
  logic [REQ_NUM-1:0][DATA_WIDTH_IN-1:0] s_tdata_i;
  logic [REQ_NUM-1:0] s_tready_o;
  logic m_tvalid_o;
  logic [DATA_WIDTH_OUT-1:0] m_tdata_o;
  logic [ID_W-1:0] m_tid_o;
  logic m_tready_i;
  modport slave (
    input s_tvalid_i, s_tdata_i, m_tready_i,
    output s_tready_o, m_tvalid_o, m_tdata_o, m_tid_o
  );
  modport master (
    output s_tvalid_i, s_tdata_i, m_tready_i,
    input s_tready_o, m_tvalid_o, m_tdata_o, m_tid_o
  );
endinterface

// File: rtl/round_core.sv
// round_core: two-stage convergent rounding of a signed sample to the upper bits
module round_core
  import round_pkg::*;
#(
  parameter int DATA_WIDTH_IN = 40,
  parameter int DATA_WIDTH_OUT = 16,
  parameter int ID_W = 2
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic tvalid_i,
  input  logic [DATA_WIDTH_IN-1:0] tdata_i,
  input  logic [ID_W-1:0] tid_i,
  input  rnd_mode_e mode_i,
  output logic tvalid_o,
  output logic [DATA_WIDTH_OUT-1:0] tdata_o,
  output logic [ID_W-1:0] tid_o
);
  localparam int SHIFT = shift_of(DATA_WIDTH_IN, DATA_WIDTH_OUT);
  localparam logic [SHIFT-1:0] HALF = {1'b1, {(SHIFT-1){1'b0}}};
  logic v1, above1, half1, odd1;
  logic [DATA_WIDTH_OUT-1:0] up1;
  logic [ID_W-1:0] id1;
  logic [SHIFT-1:0] frac;
  assign frac = tdata_i[SHIFT-1:0];
  // stage 1: split off the kept bits and classify the fraction against one half
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      v1 <= 1'b0;
      up1 <= '0;
      above1 <= 1'b0;
      half1 <= 1'b0;
      odd1 <= 1'b0;
      id1 <= '0;
    end else begin
      v1 <= tvalid_i;
      up1 <= tdata_i[DATA_WIDTH_IN-1:SHIFT];
      above1 <= frac > HALF;
      half1 <= frac == HALF;
      odd1 <= mode_i == RND_ODD;
      id1 <= tid_i;
    end
  end
  // stage 2: increment when above half, or on a tie when the LSB has the wrong parity
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      tvalid_o <= 1'b0;
      tdata_o <= '0;
      tid_o <= '0;
    end else begin
      tvalid_o <= v1;
      tdata_o <= up1 + DATA_WIDTH_OUT'(above1 | (half1 & (up1[0] ^ odd1)));
      tid_o <= id1;
    end
  end
endmodule

// File: rtl/round_sched.sv
// round_sched: round-robin arbitration of requesters into a shared rounding pipe with credit-guarded output FIFO
module round_sched
  import round_pkg::*;
#(
  parameter int REQ_NUM = 4,
  parameter int DATA_WIDTH_IN = 40,
  parameter int DATA_WIDTH_OUT = 16,
  parameter int BUF_DEPTH = 4
) (
  input logic clk_i,
  input logic rstn_i,
  input logic odd_even_i,
  round_sched_if.slave bus
);
  localparam int ID_W = id_w(REQ_NUM);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [DATA_WIDTH_OUT-1:0] data;
  } beat_t;
  logic [ID_W-1:0] last_grant, gnt_id, idx, core_id;
  logic [DATA_WIDTH_OUT-1:0] core_d;
  logic found, issue, pop, fifo_pop, push, core_v, empty;
  logic [CW-1:0] credits, count;
  logic [PW-1:0] wr_ptr, rd_ptr;
  beat_t mem [BUF_DEPTH];
  beat_t head;
  // first valid requester after the last granted one, wrapping around
  always_comb begin
    found = 1'b0;
    gnt_id = last_grant;
    idx = last_grant;
    for (int k = 1; k <= REQ_NUM; k++) begin
      idx = ID_W'((int'(last_grant) + k) % REQ_NUM);
      if (!found && bus.s_tvalid_i[idx]) begin
        found = 1'b1;
        gnt_id = idx;
      end
    end
  end
  assign issue = rstn_i && found && credits != '0;
  assign bus.s_tready_o = issue ? (REQ_NUM'(1) << gnt_id) : '0;
  round_core #(
    .DATA_WIDTH_IN(DATA_WIDTH_IN),
    .DATA_WIDTH_OUT(DATA_WIDTH_OUT),
    .ID_W(ID_W)
  ) u_core (
    .clk_i(clk_i),
    .rstn_i(rstn_i),
    .tvalid_i(issue),
    .tdata_i(bus.s_tdata_i[gnt_id]),
    .tid_i(gnt_id),
    .mode_i(rnd_mode_e'(odd_even_i)),
    .tvalid_o(core_v),
    .tdata_o(core_d),
    .tid_o(core_id)
  );
  // an empty FIFO lets the pipe result through directly so latency stays at two cycles
  assign empty = count == '0;
  assign head = empty ? {core_id, core_d} : mem[rd_ptr];
  assign bus.m_tvalid_o = !empty || core_v;
  assign bus.m_tdata_o = bus.m_tvalid_o ? head.data : '0;
  assign bus.m_tid_o = bus.m_tvalid_o ? head.id : '0;
  assign pop = bus.m_tvalid_o && bus.m_tready_i;
  assign fifo_pop = pop && !empty;
  assign push = core_v && !(pop && empty);
  // credits track free slots across pipe and FIFO; last grant moves only on accepted beats
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      credits <= CW'(BUF_DEPTH);
      last_grant <= ID_W'(REQ_NUM - 1);
    end else begin
      credits <= credits - CW'(issue) + CW'(pop);
      if (issue) last_grant <= gnt_id;
    end
  end
  // FIFO pointers and occupancy
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      count <= count + CW'(push) - CW'(fifo_pop);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (fifo_pop) rd_ptr <= rd_ptr + PW'(1);
    end
  end
  // FIFO storage, no reset needed since occupancy gates every read
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= {core_id, core_d};
  end
endmodule

// File: tb/tb_round_sched.sv
// tb_round_sched: randomized and directed checks of round_sched against an arithmetic reference model
module tb_round_sched;
  localparam int N = 4;
  localparam int WI = 40;
  localparam int WO = 16;
  localparam int BD = 4;
  localparam int S = WI - WO;
  localparam int IW = 2;
  typedef struct {
    logic [IW-1:0] id;
    logic [WO-1:0] data;
    int due;
  } exp_t;
  typedef struct {
    logic [WI-1:0] d;
    logic m;
    logic [WO-1:0] e;
  } vec_t;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic odd_even = 1'b0;
  exp_t q[$];
  logic [WO-1:0] got_d[$];
  logic [IW-1:0] got_id[$];
  int got_cyc[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last = N - 1;
  int obs_acc = 0;
  int acc;
  vec_t vecs[9] = '{
    '{40'h0001800000, 1'b0, 16'h0002}, '{40'h0002800000, 1'b0, 16'h0002},
    '{40'h0001800000, 1'b1, 16'h0001}, '{40'h0002800000, 1'b1, 16'h0003},
    '{40'h00017FFFFF, 1'b1, 16'h0001}, '{40'h0001800001, 1'b1, 16'h0002},
    '{40'h7FFF800000, 1'b0, 16'h8000}, '{40'hFFFF800000, 1'b0, 16'h0000},
    '{40'hFFFF400000, 1'b0, 16'hFFFF}
  };
  always #5 clk = ~clk;
  round_sched_if #(.REQ_NUM(N), .DATA_WIDTH_IN(WI), .DATA_WIDTH_OUT(WO)) bus ();
  round_sched #(.REQ_NUM(N), .DATA_WIDTH_IN(WI), .DATA_WIDTH_OUT(WO), .BUF_DEPTH(BD)) dut (
    .clk_i(clk),
    .rstn_i(rstn),
    .odd_even_i(odd_even),
    .bus(bus.slave)
  );
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [WO-1:0] ref_round(logic [WI-1:0] x, logic m);
    longint v = longint'($signed(x));
    longint unit = longint'(1) << S;
    longint r = v >>> S;
    longint f = v - r * unit;
    if (f > unit / 2 || (f == unit / 2 && ((r & 1) == 0) == m)) r++;
    return WO'(r);
  endfunction
  function automatic int pick();
    for (int k = 1; k <= N; k++)
      if (bus.s_tvalid_i[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction
  function automatic logic [WI-1:0] rnd_data();
    logic [WO-1:0] u = WO'($urandom);
    int sel = $urandom_range(0, 3);
    logic [S-1:0] h = {1'b1, {(S-1){1'b0}}};
    logic [S-1:0] f = sel == 0 ? h : sel == 1 ? h - 1'b1 : sel == 2 ? h + 1'b1 : S'($urandom);
    return {u, f};
  endfunction
  task automatic tick(output int a);
    int g, c;
    bit ev;
    exp_t e;
    #1;
    g = pick();
    c = BD - q.size();
    ev = q.size() > 0 && q[0].due <= cyc;
    check("s_tready", bus.s_tready_o, (g >= 0 && c > 0) ? 64'd1 << g : 64'd0);
    check("m_tvalid", bus.m_tvalid_o, ev);
    if (ev && bus.m_tready_i) begin
      check("m_tdata", bus.m_tdata_o, q[0].data);
      check("m_tid", bus.m_tid_o, q[0].id);
      void'(q.pop_front());
    end
    if ((bus.s_tready_o & bus.s_tvalid_i) != 0) obs_acc++;
    if (bus.m_tvalid_o && bus.m_tready_i) begin
      got_d.push_back(bus.m_tdata_o);
      got_id.push_back(bus.m_tid_o);
      got_cyc.push_back(cyc);
    end
    a = (g >= 0 && c > 0) ? g : -1;
    if (a >= 0) begin
      e.id = IW'(a);
      e.data = ref_round(bus.s_tdata_i[a], odd_even);
      e.due = cyc + 2;
      q.push_back(e);
      last = a;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask
  task automatic send(int r, logic [WI-1:0] d, logic m);
    int a;
    bit done = 0;
    bus.s_tvalid_i[r] = 1'b1;
    bus.s_tdata_i[r] = d;
    odd_even = m;
    for (int t = 0; t < 20 && !done; t++) begin
      tick(a);
      done = a == r;
    end
    if (!done) check("send_timeout", 0, 1);
    bus.s_tvalid_i[r] = 1'b0;
  endtask
  task automatic drain(int n);
    int a;
    for (int t = 0; t < n; t++) begin
      tick(a);
      if (a >= 0) bus.s_tvalid_i[a] = 1'b0;
    end
  endtask
  initial begin
    bus.s_tvalid_i = '1;
    bus.s_tdata_i = '0;
    bus.m_tready_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_tready", bus.s_tready_o, 0);
    check("rst_tvalid", bus.m_tvalid_o, 0);
    check("rst_tdata", bus.m_tdata_o, 0);
    check("rst_tid", bus.m_tid_o, 0);
    bus.s_tvalid_i = '0;
    @(negedge clk);
    rstn = 1'b1;
    bus.m_tready_i = 1'b1;
    foreach (vecs[i]) send(0, vecs[i].d, vecs[i].m);
    drain(4);
    check("vec_count", got_d.size(), 9);
    foreach (vecs[i]) begin
      check("vec_data", got_d[i], vecs[i].e);
      check("vec_tid", got_id[i], 0);
    end
    bus.m_tready_i = 1'b0;
    bus.s_tvalid_i[1:0] = 2'b11;
    bus.s_tdata_i[0] = rnd_data();
    bus.s_tdata_i[1] = rnd_data();
    drain(2);
    rstn = 1'b0;
    bus.s_tvalid_i = '1;
    #1;
    check("mid_rst_tvalid", bus.m_tvalid_o, 0);
    check("mid_rst_tdata", bus.m_tdata_o, 0);
    check("mid_rst_tid", bus.m_tid_o, 0);
    check("mid_rst_tready", bus.s_tready_o, 0);
    bus.s_tvalid_i = '0;
    q.delete();
    last = N - 1;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    bus.m_tready_i = 1'b1;
    got_d.delete();
    drain(6);
    check("no_stale", got_d.size(), 0);
    got_id.delete();
    got_cyc.delete();
    bus.s_tvalid_i = '1;
    for (int r = 0; r < N; r++) bus.s_tdata_i[r] = rnd_data();
    for (int t = 0; t < 16; t++) begin
      tick(acc);
      if (acc >= 0) bus.s_tdata_i[acc] = rnd_data();
    end
    drain(8);
    for (int k = 0; k < 16; k++) begin
      check("rr_tid", got_id[k], k % N);
      check("rr_rate", got_cyc[k] - got_cyc[0], k);
    end
    got_d.delete();
    obs_acc = 0;
    bus.m_tready_i = 1'b0;
    bus.s_tvalid_i = '1;
    for (int r = 0; r < N; r++) bus.s_tdata_i[r] = rnd_data();
    for (int t = 0; t < 10; t++) begin
      tick(acc);
      if (acc >= 0) bus.s_tdata_i[acc] = rnd_data();
    end
    check("bp_accepts", obs_acc, BD);
    #1;
    check("bp_tready", bus.s_tready_o, 0);
    bus.m_tready_i = 1'b1;
    drain(20);
    check("bp_drained", got_d.size(), 2 * BD);
    check("bp_issued", obs_acc, 2 * BD);
    for (int t = 0; t < 400; t++) begin
      bus.m_tready_i = $urandom_range(0, 3) != 0;
      odd_even = 1'($urandom);
      for (int r = 0; r < N; r++)
        if (!bus.s_tvalid_i[r] && $urandom_range(0, 1) == 1) begin
          bus.s_tvalid_i[r] = 1'b1;
          bus.s_tdata_i[r] = rnd_data();
        end
      tick(acc);
      if (acc >= 0) bus.s_tvalid_i[acc] = 1'b0;
    end
    bus.m_tready_i = 1'b1;
    drain(20);
    check("final_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
